// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus stages: state encoding and default
// address-decode, fill and timeout values.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMemWait,
        StIoWait
    } bus_state_e;

    localparam logic [7:0]  IO_PAGE_DEFAULT    = 8'h90;
    localparam logic [7:0]  IO_FILL_DEFAULT    = 8'hFF;
    localparam int unsigned IO_TIMEOUT_DEFAULT = 16;

    function automatic logic is_io_page(input logic [15:0] addr, input logic [7:0] page);
        return addr[15:8] == page;
    endfunction

endpackage

// File: rtl/bus_timeout_timer.sv
// Cycle counter for a pending bus access; o_expire flags the last allowed
// cycle so the owner can abort on that edge.
module bus_timeout_timer #(
    parameter int unsigned IO_TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned W = (IO_TIMEOUT > 2) ? $clog2(IO_TIMEOUT) : 1;

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_enable && (r_count == W'(IO_TIMEOUT - 1));

endmodule

// File: rtl/cpu_bus_bridge.sv
// Turns single-cycle CPU read/write pulses into held req/ack transactions on
// a memory port or an IO port, with an abort timer on the IO side.
module cpu_bus_bridge
    import cpu_bus_pkg::*;
#(
    parameter logic [7:0]  IO_PAGE    = IO_PAGE_DEFAULT,
    parameter int unsigned IO_TIMEOUT = IO_TIMEOUT_DEFAULT,
    parameter logic [7:0]  IO_FILL    = IO_FILL_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_cpu_addr,
    input  logic        i_cpu_rd_req,
    input  logic        i_cpu_wr_en,
    input  logic [7:0]  i_cpu_wr_data,
    output logic [7:0]  o_cpu_rd_data,
    output logic        o_cpu_ready,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [7:0]  o_mem_wdata,
    input  logic [7:0]  i_mem_rdata,
    input  logic        i_mem_ack,
    output logic [7:0]  o_io_addr,
    output logic        o_io_req,
    output logic        o_io_we,
    output logic [7:0]  o_io_wdata,
    input  logic [7:0]  i_io_rdata,
    input  logic        i_io_ack,
    output logic        o_timeout_pulse,
    output logic [7:0]  o_timeout_count,
    output logic        o_busy_err
);

    bus_state_e  r_state, w_state_next;
    logic [15:0] r_addr, w_addr_next;
    logic        r_we, w_we_next;
    logic [7:0]  r_wdata, w_wdata_next;
    logic [7:0]  r_rd_data, w_rd_data_next;
    logic        r_ready, w_ready_next;
    logic        r_mem_req, w_mem_req_next;
    logic        r_io_req, w_io_req_next;
    logic        r_timeout_pulse, w_timeout_pulse_next;
    logic [7:0]  r_timeout_count, w_timeout_count_next;
    logic        r_busy_err, w_busy_err_next;
    logic        w_request;
    logic        w_io_expire;

    assign w_request = i_cpu_rd_req | i_cpu_wr_en;

    bus_timeout_timer #(
        .IO_TIMEOUT (IO_TIMEOUT)
    ) u_io_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (r_state != StIoWait),
        .i_enable (r_state == StIoWait),
        .o_expire (w_io_expire)
    );

    always_comb begin
        w_state_next         = r_state;
        w_addr_next          = r_addr;
        w_we_next            = r_we;
        w_wdata_next         = r_wdata;
        w_rd_data_next       = r_rd_data;
        w_ready_next         = r_ready;
        w_mem_req_next       = r_mem_req;
        w_io_req_next        = r_io_req;
        w_timeout_pulse_next = 1'b0;
        w_timeout_count_next = r_timeout_count;
        w_busy_err_next      = 1'b0;

        case (r_state)
            StIdle: begin
                if (w_request) begin
                    // A simultaneous read and write resolves to the write.
                    w_addr_next  = i_cpu_addr;
                    w_we_next    = i_cpu_wr_en;
                    w_wdata_next = i_cpu_wr_data;
                    w_ready_next = 1'b0;
                    if (is_io_page(i_cpu_addr, IO_PAGE)) begin
                        w_io_req_next = 1'b1;
                        w_state_next  = StIoWait;
                    end else begin
                        w_mem_req_next = 1'b1;
                        w_state_next   = StMemWait;
                    end
                end
            end
            StMemWait: begin
                w_busy_err_next = w_request;
                if (i_mem_ack) begin
                    w_mem_req_next = 1'b0;
                    w_ready_next   = 1'b1;
                    w_state_next   = StIdle;
                    if (!r_we) w_rd_data_next = i_mem_rdata;
                end
            end
            StIoWait: begin
                w_busy_err_next = w_request;
                // Ack is checked first so it beats a timeout on the same edge.
                if (i_io_ack) begin
                    w_io_req_next = 1'b0;
                    w_ready_next  = 1'b1;
                    w_state_next  = StIdle;
                    if (!r_we) w_rd_data_next = i_io_rdata;
                end else if (w_io_expire) begin
                    w_io_req_next        = 1'b0;
                    w_ready_next         = 1'b1;
                    w_state_next         = StIdle;
                    w_timeout_pulse_next = 1'b1;
                    if (!r_we) w_rd_data_next = IO_FILL;
                    if (r_timeout_count != 8'hFF) begin
                        w_timeout_count_next = r_timeout_count + 8'd1;
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= StIdle;
            r_addr          <= '0;
            r_we            <= 1'b0;
            r_wdata         <= '0;
            r_rd_data       <= '0;
            r_ready         <= 1'b1;
            r_mem_req       <= 1'b0;
            r_io_req        <= 1'b0;
            r_timeout_pulse <= 1'b0;
            r_timeout_count <= '0;
            r_busy_err      <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_addr          <= w_addr_next;
            r_we            <= w_we_next;
            r_wdata         <= w_wdata_next;
            r_rd_data       <= w_rd_data_next;
            r_ready         <= w_ready_next;
            r_mem_req       <= w_mem_req_next;
            r_io_req        <= w_io_req_next;
            r_timeout_pulse <= w_timeout_pulse_next;
            r_timeout_count <= w_timeout_count_next;
            r_busy_err      <= w_busy_err_next;
        end
    end

    assign o_cpu_rd_data   = r_rd_data;
    assign o_cpu_ready     = r_ready;
    assign o_mem_addr      = r_addr;
    assign o_mem_req       = r_mem_req;
    assign o_mem_we        = r_we;
    assign o_mem_wdata     = r_wdata;
    assign o_io_addr       = r_addr[7:0];
    assign o_io_req        = r_io_req;
    assign o_io_we         = r_we;
    assign o_io_wdata      = r_wdata;
    assign o_timeout_pulse = r_timeout_pulse;
    assign o_timeout_count = r_timeout_count;
    assign o_busy_err      = r_busy_err;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Self-checking bench for cpu_bus_bridge: directed vector table, hand-written
// corner sequences and randomized transactions against a transaction model.
module tb_cpu_bus_bridge;

    typedef struct {
        logic [15:0] addr;
        logic        rd;
        logic        wr;
        logic [7:0]  wdata;
        int          ack_after;
        logic [7:0]  rdata;
        logic        exp_io;
        int          exp_cycles;
        logic [7:0]  exp_rd;
        logic        exp_to;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_rd_req, cpu_wr_en;
    logic [7:0]  cpu_wr_data, cpu_rd_data;
    logic        cpu_ready;
    logic [15:0] mem_addr;
    logic        mem_req, mem_we;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [7:0]  io_addr;
    logic        io_req, io_we;
    logic [7:0]  io_wdata, io_rdata;
    logic        io_ack;
    logic        timeout_pulse;
    logic [7:0]  timeout_count;
    logic        busy_err;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_tcount = 0;
    logic [7:0] model_rd = 8'h00;

    cpu_bus_bridge dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_cpu_addr      (cpu_addr),
        .i_cpu_rd_req    (cpu_rd_req),
        .i_cpu_wr_en     (cpu_wr_en),
        .i_cpu_wr_data   (cpu_wr_data),
        .o_cpu_rd_data   (cpu_rd_data),
        .o_cpu_ready     (cpu_ready),
        .o_mem_addr      (mem_addr),
        .o_mem_req       (mem_req),
        .o_mem_we        (mem_we),
        .o_mem_wdata     (mem_wdata),
        .i_mem_rdata     (mem_rdata),
        .i_mem_ack       (mem_ack),
        .o_io_addr       (io_addr),
        .o_io_req        (io_req),
        .o_io_we         (io_we),
        .o_io_wdata      (io_wdata),
        .i_io_rdata      (io_rdata),
        .i_io_ack        (io_ack),
        .o_timeout_pulse (timeout_pulse),
        .o_timeout_count (timeout_count),
        .o_busy_err      (busy_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one CPU access, acks it after v.ack_after request cycles and checks it.
    task automatic do_txn(input vec_t v);
        int   cyc;
        logic ok;
        check("ready_before", cpu_ready, 1'b1);
        cpu_addr    = v.addr;
        cpu_rd_req  = v.rd;
        cpu_wr_en   = v.wr;
        cpu_wr_data = v.wdata;
        tick();
        cpu_rd_req  = 1'b0;
        cpu_wr_en   = 1'b0;
        cpu_addr    = 16'($urandom);
        cpu_wr_data = 8'($urandom);
        check("ready_low", cpu_ready, 1'b0);
        check("req_port", {mem_req, io_req}, v.exp_io ? 2'b01 : 2'b10);
        cyc = 0;
        ok  = 1'b1;
        while ((mem_req || io_req) && cyc < 40) begin
            cyc++;
            if (v.exp_io) begin
                if (io_addr !== v.addr[7:0] || io_we !== v.wr || mem_req !== 1'b0) ok = 1'b0;
                if (v.wr && io_wdata !== v.wdata) ok = 1'b0;
            end else begin
                if (mem_addr !== v.addr || mem_we !== v.wr || io_req !== 1'b0) ok = 1'b0;
                if (v.wr && mem_wdata !== v.wdata) ok = 1'b0;
            end
            if (cyc - 1 == v.ack_after) begin
                if (v.exp_io) begin
                    io_ack   = 1'b1;
                    io_rdata = v.rdata;
                end else begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdata;
                end
            end
            tick();
            mem_ack   = 1'b0;
            io_ack    = 1'b0;
            mem_rdata = 8'($urandom);
            io_rdata  = 8'($urandom);
        end
        if (v.exp_to && exp_tcount < 255) exp_tcount++;
        check("held_stable", ok, 1'b1);
        check("req_cycles", cyc, v.exp_cycles);
        check("ready_after", cpu_ready, 1'b1);
        check("rd_data", cpu_rd_data, v.exp_rd);
        check("timeout_pulse", timeout_pulse, v.exp_to);
        check("timeout_count", timeout_count, exp_tcount);
        tick();
        check("pulse_cleared", timeout_pulse, 1'b0);
    endtask

    // Transaction-level reference: decides port, duration and result from the rules.
    function automatic vec_t model(input logic [15:0] addr, input logic rd, input logic wr,
                                   input logic [7:0] wdata, input int ack_after,
                                   input logic [7:0] rdata);
        vec_t v;
        v.addr = addr; v.rd = rd; v.wr = wr; v.wdata = wdata;
        v.ack_after = ack_after; v.rdata = rdata;
        v.exp_io = (addr[15:8] == 8'h90);
        v.exp_to = v.exp_io && (ack_after >= 16);
        v.exp_cycles = v.exp_to ? 16 : ack_after + 1;
        if (!wr) model_rd = v.exp_to ? 8'hFF : rdata;
        v.exp_rd = model_rd;
        return v;
    endfunction

    vec_t table_v[8];
    vec_t v;

    initial begin
        reset = 1'b1;
        cpu_addr = '0; cpu_rd_req = 1'b0; cpu_wr_en = 1'b0; cpu_wr_data = '0;
        mem_rdata = '0; mem_ack = 1'b0; io_rdata = '0; io_ack = 1'b0;

        //            addr      rd    wr    wdata  ack rdata  io    cyc rd     to
        table_v[0] = '{16'h1234, 1'b1, 1'b0, 8'h00, 0,  8'h5A, 1'b0, 1,  8'h5A, 1'b0};
        table_v[1] = '{16'h9010, 1'b0, 1'b1, 8'h77, 2,  8'hEE, 1'b1, 3,  8'h5A, 1'b0};
        table_v[2] = '{16'h9001, 1'b1, 1'b0, 8'h00, 99, 8'h12, 1'b1, 16, 8'hFF, 1'b1};
        table_v[3] = '{16'h0400, 1'b1, 1'b1, 8'h3C, 1,  8'h99, 1'b0, 2,  8'hFF, 1'b0};
        table_v[4] = '{16'h90AB, 1'b1, 1'b0, 8'h00, 15, 8'hC3, 1'b1, 16, 8'hC3, 1'b0};
        table_v[5] = '{16'h8FFF, 1'b1, 1'b0, 8'h00, 4,  8'h11, 1'b0, 5,  8'h11, 1'b0};
        table_v[6] = '{16'h91FF, 1'b1, 1'b0, 8'h00, 0,  8'h22, 1'b0, 1,  8'h22, 1'b0};
        table_v[7] = '{16'h90FF, 1'b1, 1'b0, 8'h00, 14, 8'h44, 1'b1, 15, 8'h44, 1'b0};

        repeat (2) tick();
        check("rst_ready", cpu_ready, 1'b1);
        check("rst_rd_data", cpu_rd_data, 8'h00);
        check("rst_reqs", {mem_req, io_req, mem_we, io_we}, 4'b0000);
        check("rst_addr", {mem_addr, io_wdata}, 24'h0);
        check("rst_count", timeout_count, 8'h00);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) do_txn(table_v[i]);
        model_rd = 8'h44;

        // Second request while a memory access is pending.
        cpu_addr = 16'h2222; cpu_rd_req = 1'b1;
        tick();
        cpu_rd_req = 1'b0;
        tick();
        cpu_addr = 16'h3333; cpu_rd_req = 1'b1;
        tick();
        cpu_rd_req = 1'b0;
        check("busy_err_pulse", busy_err, 1'b1);
        check("busy_addr_kept", mem_addr, 16'h2222);
        tick();
        check("busy_err_clear", busy_err, 1'b0);
        mem_ack = 1'b1; mem_rdata = 8'h66;
        tick();
        mem_ack = 1'b0;
        check("busy_complete", {mem_req, cpu_ready, cpu_rd_data}, {2'b01, 8'h66});
        model_rd = 8'h66;
        tick();

        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            logic [1:0]  sel;
            a = 16'($urandom);
            if ($urandom_range(0, 2) == 0) a[15:8] = 8'h90;
            sel = 2'($urandom_range(1, 3));
            v = model(a, sel[0], sel[1], 8'($urandom), int'($urandom_range(0, 20)),
                      8'($urandom));
            do_txn(v);
        end

        // Asynchronous reset in the middle of a memory access.
        cpu_addr = 16'h5555; cpu_rd_req = 1'b1;
        tick();
        cpu_rd_req = 1'b0;
        tick();
        #3 reset = 1'b1;
        #1;
        check("async_rst_req", mem_req, 1'b0);
        check("async_rst_ready", cpu_ready, 1'b1);
        check("async_rst_state", {cpu_rd_data, timeout_count}, 16'h0);
        tick();
        reset = 1'b0;
        tick();
        exp_tcount = 0;
        model_rd = 8'h00;
        do_txn(model(16'h0123, 1'b1, 1'b0, 8'h00, 2, 8'hA7));

        for (int i = 0; i < 300; i++) do_txn(model(16'h9001, 1'b1, 1'b0, 8'h00, 99, 8'h00));
        check("count_saturated", timeout_count, 8'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_bus_bridge.md
Name: cpu_bus_bridge

Overview:
- Downstream stage of the test CPU's bus port. It takes the CPU's single-cycle rd_req/wr_en pulses and turns them into held request/ack transactions on a memory port or an IO port.
- It owns the CPU `ready` signal and returns read data.
- The CPU presents addr only during its request cycle, so the bridge latches the address, the direction and the write data.
- The IO port has a timeout so a silent peripheral cannot hang the CPU.

Parameters:
IO_PAGE, 8'h90, addr[15:8] value selecting the IO port; all other addresses go to the memory port.
IO_TIMEOUT, 16, cycles io_req may stay high without io_ack before the access is aborted (must be >= 2).
IO_FILL, 8'hFF, read data returned on an IO timeout.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cpu_addr  in  16  CPU address, valid only in the cycle rd_req/wr_en is high
cpu_rd_req  in  1  single-cycle read request pulse
cpu_wr_en  in  1  single-cycle write pulse
cpu_wr_data  in  8  write data, valid with cpu_wr_en
cpu_rd_data  out  8  read data, held until the next completed read
cpu_ready  out  1  1 = idle / last access complete
mem_addr  out  16  latched address
mem_req  out  1  held high until mem_ack
mem_we  out  1  1 = write
mem_wdata  out  8  write data
mem_rdata  in  8  sampled in the mem_ack cycle
mem_ack  in  1  completion strobe
io_addr  out  8  latched addr[7:0]
io_req  out  1  held high until io_ack or timeout
io_we  out  1  1 = write
io_wdata  out  8  write data
io_rdata  in  8  sampled in the io_ack cycle
io_ack  in  1  completion strobe
timeout_pulse  out  1  one-cycle pulse when an IO access is aborted
timeout_count  out  8  saturating count of IO timeouts
busy_err  out  1  one-cycle pulse when a request arrives while busy

Behaviour:
- Reset (async, active-high): state=IDLE, cpu_ready=1, cpu_rd_data=0, all req/we=0, addr/wdata outputs=0, timeout_count=0, pulses=0. A reset during a transaction drops req immediately; the downstream side must tolerate an abandoned access.
- All outputs are registered.
- States: IDLE, MEM_WAIT, IO_WAIT.
- IDLE, on the edge where cpu_rd_req or cpu_wr_en is sampled high:
  - latch address, we=cpu_wr_en, wdata=cpu_wr_data;
  - cpu_ready<=0;
  - if addr[15:8]==IO_PAGE: io_req<=1, go to IO_WAIT with the timer cleared; else mem_req<=1, go to MEM_WAIT.
- If cpu_rd_req and cpu_wr_en are high together, the access is a write and the read is dropped.
- MEM_WAIT:
  - mem_req, address, we and wdata stay stable until mem_ack is sampled high.
  - On that edge: mem_req<=0, cpu_ready<=1, state=IDLE; on a read, cpu_rd_data<=mem_rdata.
  - No timeout.
- IO_WAIT:
  - Same handshake using io_ack/io_rdata.
  - The timer increments each cycle io_req is high.
  - If the timer reaches IO_TIMEOUT-1 with io_ack low on that edge: io_req<=0, cpu_ready<=1, reads get cpu_rd_data<=IO_FILL, timeout_pulse<=1, timeout_count saturating +1 (holds at 255), state=IDLE.
  - If io_ack and the timeout coincide on the same edge, the ack wins (normal completion, no timeout).
- Minimum latency: request sampled at edge E0, req high in cycle E0..E1, ack in that cycle, cpu_ready=1 after E1. cpu_ready therefore goes low the edge after the request pulse, which is the cycle the CPU first checks it.
- Writes: cpu_rd_data is unchanged.
- Requests sampled while state!=IDLE are ignored, the latched values are unchanged, and busy_err pulses for 1 cycle.
- mem_ack/io_ack outside their own WAIT state are ignored.
- Back-to-back: a request may be accepted on the first edge after returning to IDLE (cpu_ready=1).

Decomposition:
- Shared package cpu_bus_pkg holds: the state encoding (IDLE/MEM_WAIT/IO_WAIT), default IO_PAGE, IO_FILL and the default timeout value. Other bus stages reuse these.
- One sub-module: bus_timeout_timer (clear/enable inputs, expire output, IO_TIMEOUT parameter). Instantiated for the IO path.

Test Plan:
- Read 0x1234, memory acks in the first req cycle with mem_rdata=0x5A -> mem_req high exactly 1 cycle, mem_addr=0x1234, cpu_ready low 1 cycle, then cpu_rd_data=0x5A.
- Write 0x9010 data 0x77, io_ack after 3 cycles -> io_addr=0x10, io_we=1, io_wdata=0x77 stable for 3 cycles; cpu_ready returns the cycle after ack; cpu_rd_data unchanged.
- IO read 0x9001 with io_ack never asserted -> io_req drops after 16 cycles, cpu_rd_data=0xFF, timeout_pulse once, timeout_count=1. Repeat 300 times -> count stays 255.
- Second cpu_rd_req during MEM_WAIT -> busy_err 1-cycle pulse, mem_addr unchanged, the original transaction completes normally.
- Simultaneous rd_req+wr_en to 0x0400 -> mem_we=1, treated as write. Separately, io_ack on the timeout edge -> io_rdata returned, no timeout_pulse.
- Assert reset mid-MEM_WAIT -> mem_req=0 and cpu_ready=1 immediately (async). After release, a new read completes normally.
